branch_predictor: RTL

Fetch-stage branch predictor for the pipelined RV32I core: a 5-bit global-history gshare direction predictor plus a direct-mapped branch target buffer (BTB). It drives the `predict_regs` bundle (`bhr`, `taken`, `btb_address`) carried down the pipeline with each fetched instruction. It is trained by the execute stage when a control-flow instruction resolves. It also keeps the `branch_total` / `branch_incorrect` event counts consumed by the performance-counter block.

---
 rtl/branch_predictor.sv | 102 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage gshare direction predictor (5-bit global history, 32-entry PHT)
// with a direct-mapped BTB, execute-stage training and branch event counters.
module branch_predictor #(
    parameter int BTB_ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    output logic [37:0] pred,                 // {bhr[4:0], taken, btb_address[31:0]}
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic [4:0]  resolve_bhr,
    input  logic        resolve_is_br,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_mispredict,
    input  logic        ctr_clear,
    output logic [31:0] branch_total_cnt,
    output logic [31:0] branch_incorrect_cnt
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [4:0]      bhr;
    logic [1:0]      pht        [32];
    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]     btb_target [BTB_ENTRIES];
    logic            btb_cond   [BTB_ENTRIES];
    logic [31:0]     total_q;
    logic [31:0]     incorrect_q;

    logic [IDX-1:0]  f_idx;
    logic [IDX-1:0]  r_idx;
    logic [4:0]      f_pht_idx;
    logic [4:0]      r_pht_idx;
    logic            f_hit;
    logic            f_cond;
    logic            pred_taken;
    logic [31:0]     pred_addr;
    logic            unused_ok;

    assign unused_ok = ^{fetch_pc[1:0], resolve_pc[1:0]};

    assign f_idx      = fetch_pc[IDX+1:2];
    assign r_idx      = resolve_pc[IDX+1:2];
    assign f_pht_idx  = fetch_pc[6:2] ^ bhr;
    assign r_pht_idx  = resolve_pc[6:2] ^ resolve_bhr;
    assign f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == fetch_pc[31:IDX+2]);
    assign f_cond     = btb_cond[f_idx];
    assign pred_taken = f_hit && (!f_cond || pht[f_pht_idx][1]);
    assign pred_addr  = pred_taken ? btb_target[f_idx] : fetch_pc + 32'd4;
    assign pred       = {bhr, pred_taken, pred_addr};

    assign branch_total_cnt     = total_q;
    assign branch_incorrect_cnt = incorrect_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bhr         <= '0;
            total_q     <= '0;
            incorrect_q <= '0;
            for (int i = 0; i < 32; i++) pht[i] <= 2'b01;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_cond[i]   <= 1'b0;
            end
        end else begin
            // Recovery from a resolved mispredict takes priority over the speculative shift.
            if (resolve_valid && resolve_mispredict)
                bhr <= resolve_is_br ? {resolve_bhr[3:0], resolve_taken} : resolve_bhr;
            else if (fetch_valid && f_hit && f_cond)
                bhr <= {bhr[3:0], pred_taken};

            if (resolve_valid && resolve_is_br) begin
                if (resolve_taken) begin
                    if (pht[r_pht_idx] != 2'b11) pht[r_pht_idx] <= pht[r_pht_idx] + 2'd1;
                end else begin
                    if (pht[r_pht_idx] != 2'b00) pht[r_pht_idx] <= pht[r_pht_idx] - 2'd1;
                end
            end

            if (resolve_valid && resolve_taken) begin
                btb_valid[r_idx]  <= 1'b1;
                btb_tag[r_idx]    <= resolve_pc[31:IDX+2];
                btb_target[r_idx] <= resolve_target;
                btb_cond[r_idx]   <= resolve_is_br;
            end

            if (ctr_clear) begin
                total_q     <= '0;
                incorrect_q <= '0;
            end else if (resolve_valid) begin
                total_q <= total_q + 32'd1;
                if (resolve_mispredict) incorrect_q <= incorrect_q + 32'd1;
            end
        end
    end
endmodule
